mp_arith_unit: RTL and testbench
================================

# mp_arith_unit

Parametrised digit-serial multi-precision arithmetic unit for the RSA datapath. One instance replaces the fixed 32-bit compare, add, subtract and multiply blocks. It processes D-bit digits per clock over W-bit operands and selects the operation with an opcode. A start/busy/done handshake lets the modular-exponentiation controller sequence it without knowing per-operation latencies.

## Interface
- W, 32, operand width in bits; must be a multiple of D.
- D, 8, digit width in bits; N = W/D digits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE or DONE.
- op  in  2  operation: 0 ADD, 1 SUB, 2 CMP, 3 MUL; sampled with start.
- a  in  W  operand A; sampled with start.
- b  in  W  operand B; sampled with start.
- busy  out  1  high while an operation runs.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  2W  ADD/SUB use [W-1:0] with the upper half 0; MUL uses the full 2W; CMP gives 0.
- carry  out  1  ADD: carry out. SUB: borrow, 1 iff a < b. Otherwise 0.
- gt  out  1  CMP: a > b. Otherwise 0.
- eq  out  1  CMP: a == b. Otherwise 0.

Clock is one domain, `clk`. Reset is asynchronous and active-low (`rst_n`).

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN when start is accepted.
  - RUN → DONE after the last step.
  - DONE → RUN on start, else DONE → IDLE.
- Accepting start:
  - latches a, b and op;
  - clears result, carry, gt and eq;
  - clears the step counter.
- start during RUN is ignored and has no side effects.
- ADD:
  - N steps, least-significant digit first.
  - Each step computes digit_a + digit_b + c, writes D result bits, and registers the carry.
  - carry = final carry out.
- SUB:
  - Same as ADD with digit_a + ~digit_b + c, and c initialised to 1.
  - carry = NOT of the final carry, i.e. the borrow.
  - result = (a − b) mod 2^W.
- CMP:
  - Most-significant digit first.
  - Stops at the first unequal digit: gt = (digit_a > digit_b), eq = 0.
  - If all N digits are equal: gt = 0, eq = 1.
  - Step count k is the 1-based index of the first differing digit from the MSB; k = N if a == b.
- MUL:
  - N·N steps; i is the outer loop over b digits, j the inner loop over a digits.
  - Each step adds (a_j · b_i) << D·(i+j) to the 2W accumulator.
  - The final result is the exact 2W-bit product; the accumulator never overflows.
- Outputs are valid when done = 1 and held stable until the next accepted start.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, carry 0, gt 0, eq 0, counters 0.
- Latency from the start edge t:
  - busy = 1 from after edge t.
  - Steps L: ADD/SUB L = N, MUL L = N², CMP L = k.
  - After edge t+L+1: done = 1 and busy = 0 for exactly one cycle.
- Back-to-back: start high in the DONE cycle is accepted, so busy stays low for only that one cycle; throughput is L+1 cycles per operation.
- result, carry, gt and eq change only on an accepted start or during RUN, never in IDLE or DONE.
- rst_n asserted mid-operation immediately forces all reset values. No done pulse is produced for the aborted operation.
- The step counter is sized ⌈log2(N²+1)⌉ bits. The MUL indices wrap j: N−1 → 0 with i incremented.

## Structure
- Shared package mp_arith_pkg holds:
  - the op encoding constants OP_ADD, OP_SUB, OP_CMP, OP_MUL;
  - the state encoding for IDLE/RUN/DONE.
- Sub-module mp_digit_alu, combinational, parametrised by D:
  - D-bit add/subtract with carry in and out;
  - D-bit compare (gt, eq);
  - D×D → 2D product.
- The top level holds the FSM, the operand shift registers, the step and index counters, and the 2W accumulator.

## Test plan
All cases use W=32, D=8 unless stated.
- ADD a=0xFFFFFFFF, b=0x00000001 → result=0, carry=1; done after edge t+5, one cycle wide.
- SUB a=0x00000000, b=0x00000001 → result=0xFFFFFFFF, carry=1; SUB 5−3 → result=2, carry=0.
- CMP a=0x12345678, b=0x12345578 → gt=1, eq=0, done after edge t+4.
  - CMP a=b=0xDEADBEEF → gt=0, eq=1, done after edge t+5.
  - CMP 0x01000000 vs 0x02000000 → gt=0, eq=0, done after edge t+2.
- MUL a=b=0xFFFFFFFF → result=0xFFFFFFFE00000001, done after edge t+17.
  - Repeat with W=64, D=16 against a random reference product.
- Start pulsed during a MUL RUN → ignored, result unchanged. Start in the DONE cycle → accepted; the second result is correct.
- rst_n low at step 7 of a MUL → all outputs return to reset values immediately; no done pulse; a fresh ADD afterwards is correct.

Source files
------------

// File: rtl/mp_arith_pkg.sv
// Shared encodings for the multi-precision arithmetic unit.
package mp_arith_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_CMP = 2'd2;
   localparam logic [1:0] OP_MUL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : mp_arith_pkg

// File: rtl/mp_digit_alu.sv
// Combinational single-digit datapath: add/sub with carry, compare, and full product.
module mp_digit_alu #(
   parameter int unsigned D = 8
) (
   input  logic [D-1:0]   dig_a,
   input  logic [D-1:0]   dig_b,
   input  logic           cin,
   input  logic           sub,
   output logic [D-1:0]   sum_c,
   output logic           cout_c,
   output logic           gt_c,
   output logic           eq_c,
   output logic [2*D-1:0] prod_c
);

   localparam int unsigned D1 = D + 1;
   localparam int unsigned D2 = 2 * D;

   logic [D-1:0] b_eff;
   logic [D:0]   add_full;

   // Subtraction reuses the adder with the B digit inverted.
   always_comb begin
      b_eff    = sub ? ~dig_b : dig_b;
      add_full = D1'(dig_a) + D1'(b_eff) + D1'(cin);
      sum_c    = add_full[D-1:0];
      cout_c   = add_full[D];
      gt_c     = (dig_a > dig_b);
      eq_c     = (dig_a == dig_b);
      prod_c   = D2'(dig_a) * D2'(dig_b);
   end

endmodule : mp_digit_alu

// File: rtl/mp_arith_unit.sv
// Digit-serial multi-precision ADD/SUB/CMP/MUL unit with start/busy/done handshake.
module mp_arith_unit
   import mp_arith_pkg::*;
#(
   parameter int unsigned W = 32,
   parameter int unsigned D = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           carry,
   output logic           gt,
   output logic           eq
);

   localparam int unsigned N  = W / D;
   localparam int unsigned W2 = 2 * W;
   localparam int unsigned CW = $clog2(N * N + 1);
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic [1:0]      op_q, op_d;
   logic [W2-1:0]   result_q, result_d;
   logic            carry_q, carry_d, gt_q, gt_d, eq_q, eq_d;
   logic            c_q, c_d;
   logic            last_q, last_d;
   logic            busy_d, done_d;
   logic [CW-1:0]   step_q, step_d;
   logic [IW-1:0]   i_q, i_d, j_q, j_d;

   logic [D-1:0]    dig_a, dig_b, sum_c;
   logic            cout_c, dgt_c, deq_c;
   logic [2*D-1:0]  prod_c;
   logic [31:0]     mul_sh;
   logic [W2-1:0]   mul_addend;

   // CMP walks from the most significant digit; the other ops from the least.
   always_comb begin
      dig_a      = (op_q == OP_CMP) ? a_q[W-1 -: D] : a_q[D-1:0];
      dig_b      = (op_q == OP_CMP) ? b_q[W-1 -: D] : b_q[D-1:0];
      mul_sh     = 32'(D) * (32'(i_q) + 32'(j_q));
      mul_addend = W2'(prod_c) << mul_sh;
   end

   mp_digit_alu #(.D(D)) u_alu (
      .dig_a  (dig_a),
      .dig_b  (dig_b),
      .cin    (c_q),
      .sub    (op_q == OP_SUB),
      .sum_c  (sum_c),
      .cout_c (cout_c),
      .gt_c   (dgt_c),
      .eq_c   (deq_c),
      .prod_c (prod_c)
   );

   // Next-state and next-datapath logic; last_q marks that the final step has been taken.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      carry_d  = carry_q;
      gt_d     = gt_q;
      eq_d     = eq_q;
      c_d      = c_q;
      last_d   = last_q;
      step_d   = step_q;
      i_d      = i_q;
      j_d      = j_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               state_d  = ST_RUN;
               a_d      = a;
               b_d      = b;
               op_d     = op;
               result_d = '0;
               carry_d  = 1'b0;
               gt_d     = 1'b0;
               eq_d     = 1'b0;
               c_d      = (op == OP_SUB);
               last_d   = 1'b0;
               step_d   = '0;
               i_d      = '0;
               j_d      = '0;
            end
         end
         ST_RUN: begin
            if (last_q) begin
               state_d = ST_DONE;
            end else begin
               step_d = step_q + CW'(1);
               case (op_q)
                  OP_ADD, OP_SUB: begin
                     result_d[W-1:0] = {sum_c, result_q[W-1:D]};
                     c_d             = cout_c;
                     a_d             = a_q >> D;
                     b_d             = b_q >> D;
                     if (step_q == CW'(N - 1)) begin
                        last_d  = 1'b1;
                        carry_d = (op_q == OP_SUB) ? ~cout_c : cout_c;
                     end
                  end
                  OP_CMP: begin
                     a_d = a_q << D;
                     b_d = b_q << D;
                     if (!deq_c) begin
                        gt_d   = dgt_c;
                        last_d = 1'b1;
                     end else if (step_q == CW'(N - 1)) begin
                        eq_d   = 1'b1;
                        last_d = 1'b1;
                     end
                  end
                  OP_MUL: begin
                     result_d = result_q + mul_addend;
                     a_d      = {a_q[D-1:0], a_q[W-1:D]};
                     if (j_q == IW'(N - 1)) begin
                        j_d = '0;
                        i_d = i_q + IW'(1);
                        b_d = b_q >> D;
                     end else begin
                        j_d = j_q + IW'(1);
                     end
                     if (step_q == CW'(N * N - 1)) begin
                        last_d = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_q == ST_RUN) && (state_d == ST_DONE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_ADD;
         result_q <= '0;
         carry_q  <= 1'b0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
         c_q      <= 1'b0;
         last_q   <= 1'b0;
         step_q   <= '0;
         i_q      <= '0;
         j_q      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         gt_q     <= gt_d;
         eq_q     <= eq_d;
         c_q      <= c_d;
         last_q   <= last_d;
         step_q   <= step_d;
         i_q      <= i_d;
         j_q      <= j_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   assign result = result_q;
   assign carry  = carry_q;
   assign gt     = gt_q;
   assign eq     = eq_q;

endmodule : mp_arith_unit

// File: tb/tb_mp_arith_unit.sv
// Directed-vector bench for mp_arith_unit (W=32/D=8 plus a W=64/D=16 instance).
module tb_mp_arith_unit;

   localparam logic [1:0] ADD = 2'd0;
   localparam logic [1:0] SUB = 2'd1;
   localparam logic [1:0] CMP = 2'd2;
   localparam logic [1:0] MUL = 2'd3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic [31:0]  a, b;
   logic         busy, done, carry, gt, eq;
   logic [63:0]  result;

   logic         start2;
   logic [1:0]   op2;
   logic [63:0]  a2, b2;
   logic         busy2, done2, carry2, gt2, eq2;
   logic [127:0] result2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mp_arith_unit #(.W(32), .D(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carry(carry), .gt(gt), .eq(eq)
   );

   mp_arith_unit #(.W(64), .D(16)) dut64 (
      .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .result(result2), .carry(carry2), .gt(gt2), .eq(eq2)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called #1 after a posedge; the next posedge accepts the request.
   task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after the accepting edge until done; poke>0 raises start for one cycle mid-run.
   task automatic wait_done(input string tag, input int exp_lat, input int poke);
      int lat;
      lat = -1;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk);
         #1;
         if (n == poke) begin
            start = 1'b1; op = ADD; a = 32'h1; b = 32'h1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            lat = n;
            break;
         end
      end
      start = 1'b0;
      check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
      check({tag, "_busy_at_done"}, 128'(busy), 128'(0));
   endtask

   task automatic quiet_cycle(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_done_width"}, 128'(done), 128'(0));
      check({tag, "_idle_busy"}, 128'(busy), 128'(0));
   endtask

   initial begin
      logic [63:0]  exp_prod;
      logic [127:0] exp_prod2;
      logic         saw_done;
      rst_n = 1'b0; start = 1'b0; op = ADD; a = '0; b = '0;
      start2 = 1'b0; op2 = ADD; a2 = '0; b2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",   128'(busy),   128'(0));
      check("rst_done",   128'(done),   128'(0));
      check("rst_result", 128'(result), 128'(0));
      check("rst_flags",  128'({carry, gt, eq}), 128'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADD with full carry ripple
      start_op(ADD, 32'hFFFF_FFFF, 32'h0000_0001);
      check("add_busy_after_start", 128'(busy), 128'(1));
      wait_done("add", 5, 0);
      check("add_result", 128'(result), 128'(0));
      check("add_carry",  128'(carry),  128'(1));
      quiet_cycle("add");
      @(posedge clk); #1;
      check("add_hold_idle", 128'(result), 128'(0));

      // SUB with borrow, then SUB back-to-back from DONE
      start_op(SUB, 32'h0000_0000, 32'h0000_0001);
      wait_done("sub0", 5, 0);
      check("sub0_result", 128'(result), 128'(64'h0000_0000_FFFF_FFFF));
      check("sub0_borrow", 128'(carry),  128'(1));
      start_op(SUB, 32'd5, 32'd3);
      check("sub1_b2b_busy", 128'(busy), 128'(1));
      wait_done("sub1", 5, 0);
      check("sub1_result", 128'(result), 128'(2));
      check("sub1_borrow", 128'(carry),  128'(0));
      quiet_cycle("sub1");

      // CMP: early exit at digit 3, full equality, and first-digit difference
      start_op(CMP, 32'h1234_5678, 32'h1234_5578);
      wait_done("cmp_gt", 4, 0);
      check("cmp_gt_flags", 128'({gt, eq}), 128'(2'b10));
      check("cmp_gt_result", 128'(result), 128'(0));
      start_op(CMP, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      wait_done("cmp_eq", 5, 0);
      check("cmp_eq_flags", 128'({gt, eq}), 128'(2'b01));
      start_op(CMP, 32'h0100_0000, 32'h0200_0000);
      wait_done("cmp_lt", 2, 0);
      check("cmp_lt_flags", 128'({gt, eq}), 128'(2'b00));
      quiet_cycle("cmp_lt");

      // MUL with a stray start mid-run, then ADD accepted in the DONE cycle
      start_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mul_ff", 17, 6);
      check("mul_ff_result", 128'(result), 128'(64'hFFFF_FFFE_0000_0001));
      check("mul_ff_flags",  128'({carry, gt, eq}), 128'(0));
      start_op(ADD, 32'h1234_5678, 32'h1111_1111);
      wait_done("add_b2b", 5, 0);
      check("add_b2b_result", 128'(result), 128'(64'h0000_0000_2345_6789));
      check("add_b2b_carry",  128'(carry),  128'(0));

      exp_prod = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
      start_op(MUL, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_done("mul_mix", 17, 0);
      check("mul_mix_result", 128'(result), 128'(exp_prod));
      quiet_cycle("mul_mix");

      // Reset in the middle of a MUL
      start_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy",   128'(busy),   128'(0));
      check("abort_done",   128'(done),   128'(0));
      check("abort_result", 128'(result), 128'(0));
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         saw_done = saw_done | done;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         saw_done = saw_done | done;
      end
      check("abort_no_done", 128'(saw_done), 128'(0));
      start_op(ADD, 32'd2, 32'd3);
      wait_done("post_abort_add", 5, 0);
      check("post_abort_result", 128'(result), 128'(5));

      // Wider instance: W=64, D=16
      exp_prod2 = 128'(64'h0123_4567_89AB_CDEF) * 128'(64'hFEDC_BA98_7654_3210);
      for (int v = 0; v < 2; v++) begin
         int lat;
         start2 = 1'b1;
         op2    = MUL;
         a2     = (v == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0123_4567_89AB_CDEF;
         b2     = (v == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFEDC_BA98_7654_3210;
         @(posedge clk); #1;
         start2 = 1'b0;
         lat = -1;
         for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (done2) begin
               lat = n;
               break;
            end
         end
         check("mul64_lat", 128'(lat), 128'(17));
         check("mul64_result", result2,
               (v == 0) ? 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 : exp_prod2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mp_arith_unit
